// File: rtl/dht_onewire_reader_if.sv
// Request/result bundle between a DHT single-wire reader and the logic that consumes its frames.
interface dht_onewire_reader_if #(
    parameter int unsigned N_BITS = 40
);
    localparam int unsigned BC_W = $clog2(N_BITS) + 1;

    logic              trigger;
    logic [N_BITS-1:0] data_out;
    logic              data_valid;
    logic              chk_err;
    logic              timeout_err;
    logic              busy;
    logic [BC_W-1:0]   bit_cnt;

    modport master (output trigger, input data_out, data_valid, chk_err, timeout_err, busy, bit_cnt);
    modport slave  (input trigger, output data_out, data_valid, chk_err, timeout_err, busy, bit_cnt);
endinterface

// File: rtl/dht_onewire_reader.sv
// DHT11/DHT22 single-wire reader: open-drain start pulse, response/bit timing with
// per-phase timeouts, checksum validation and one-cycle status pulses.
module dht_onewire_reader #(
    parameter int unsigned CLK_PER_US      = 1,
    parameter int unsigned START_LOW_US    = 18000,
    parameter int unsigned RESP_TIMEOUT_US = 200,
    parameter int unsigned BIT_THRESH_US   = 50,
    parameter int unsigned N_BITS          = 40,
    parameter bit          CHK_EN          = 1'b1
) (
    input  logic                 clk1M,
    input  logic                 rst_n,
    inout  wire                  dht_io,
    dht_onewire_reader_if.slave  bus
);
    localparam int unsigned CNT_W   = 20;
    localparam int unsigned PRE_W   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam int unsigned BC_W    = $clog2(N_BITS) + 1;
    localparam int unsigned N_BYTES = N_BITS / 8;

    localparam logic [CNT_W-1:0] START_TICKS   = CNT_W'(START_LOW_US);
    localparam logic [CNT_W-1:0] TIMEOUT_TICKS = CNT_W'(RESP_TIMEOUT_US);
    localparam logic [CNT_W-1:0] THRESH_TICKS  = CNT_W'(BIT_THRESH_US);
    localparam logic [PRE_W-1:0] PRE_LAST      = PRE_W'(CLK_PER_US - 1);
    localparam logic [BC_W-1:0]  FRAME_BITS    = BC_W'(N_BITS);

    typedef enum logic [2:0] {
        IDLE, START_LOW, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK
    } state_t;

    state_t              state_q, state_n;
    logic [PRE_W-1:0]    pre_q, pre_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n, elapsed;
    logic [N_BITS-1:0]   sr_q, sr_n, data_q, data_n;
    logic [BC_W-1:0]     bit_cnt_q, bit_cnt_n;
    logic                dv_q, dv_n, ce_q, ce_n, te_q, te_n;
    logic                busy_q, busy_d_q, drive_low_q;
    logic [2:0]          trig_sync_q, io_sync_q;
    logic                trig_rise, io_rise, io_fall, tick, timed;
    logic [7:0]          sum;

    assign trig_rise = trig_sync_q[1] & ~trig_sync_q[2];
    assign io_rise   = io_sync_q[1] & ~io_sync_q[2];
    assign io_fall   = ~io_sync_q[1] & io_sync_q[2];
    assign tick      = (pre_q == PRE_LAST);
    // Count including the tick landing this cycle, so exits see the full elapsed time.
    assign elapsed   = (tick && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
    assign timed     = state_q inside {WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH};

    // Wraparound sum of all bytes above the checksum byte.
    always_comb begin
        sum = '0;
        for (int i = 1; i < int'(N_BYTES); i++) begin
            sum = sum + sr_q[8*i +: 8];
        end
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_n;
    end

    always_comb begin
        state_n   = state_q;
        pre_n     = tick ? '0 : pre_q + PRE_W'(1);
        cnt_n     = elapsed;
        sr_n      = sr_q;
        bit_cnt_n = bit_cnt_q;
        data_n    = data_q;
        dv_n      = 1'b0;
        ce_n      = 1'b0;
        te_n      = 1'b0;
        case (state_q)
            IDLE: begin
                // busy_d_q masks an edge arriving right as the previous read finishes.
                if (trig_rise && !busy_d_q) begin
                    state_n   = START_LOW;
                    sr_n      = '0;
                    bit_cnt_n = '0;
                end
            end
            START_LOW: if (elapsed >= START_TICKS) state_n = WAIT_RESP;
            WAIT_RESP: if (io_fall) state_n = RESP_LOW;
            RESP_LOW:  if (io_rise) state_n = RESP_HIGH;
            RESP_HIGH: if (io_fall) state_n = BIT_LOW;
            BIT_LOW:   if (io_rise) state_n = BIT_HIGH;
            BIT_HIGH: begin
                if (io_fall) begin
                    sr_n      = {sr_q[N_BITS-2:0], (elapsed > THRESH_TICKS)};
                    bit_cnt_n = bit_cnt_q + BC_W'(1);
                    state_n   = (bit_cnt_n == FRAME_BITS) ? CHECK : BIT_LOW;
                end
            end
            CHECK: begin
                if (!CHK_EN || (sum == sr_q[7:0])) begin
                    data_n = sr_q;
                    dv_n   = 1'b1;
                end else begin
                    ce_n   = 1'b1;
                end
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (timed && (state_n == state_q) && (elapsed > TIMEOUT_TICKS)) begin
            state_n = IDLE;
            te_n    = 1'b1;
        end
        if (state_n != state_q) begin
            cnt_n = '0;
            pre_n = '0;
        end
    end

    always_ff @(posedge clk1M or negedge rst_n) begin
        if (!rst_n) begin
            pre_q       <= '0;
            cnt_q       <= '0;
            sr_q        <= '0;
            data_q      <= '0;
            bit_cnt_q   <= '0;
            dv_q        <= 1'b0;
            ce_q        <= 1'b0;
            te_q        <= 1'b0;
            busy_q      <= 1'b0;
            busy_d_q    <= 1'b0;
            drive_low_q <= 1'b0;
            trig_sync_q <= '0;
            io_sync_q   <= '0;
        end else begin
            pre_q       <= pre_n;
            cnt_q       <= cnt_n;
            sr_q        <= sr_n;
            data_q      <= data_n;
            bit_cnt_q   <= bit_cnt_n;
            dv_q        <= dv_n;
            ce_q        <= ce_n;
            te_q        <= te_n;
            busy_q      <= (state_n != IDLE);
            busy_d_q    <= busy_q;
            drive_low_q <= (state_n == START_LOW);
            trig_sync_q <= {trig_sync_q[1:0], bus.trigger};
            io_sync_q   <= {io_sync_q[1:0], dht_io};
        end
    end

    assign dht_io          = drive_low_q ? 1'b0 : 1'bz;
    assign bus.data_out    = data_q;
    assign bus.data_valid  = dv_q;
    assign bus.chk_err     = ce_q;
    assign bus.timeout_err = te_q;
    assign bus.busy        = busy_q;
    assign bus.bit_cnt     = bit_cnt_q;
endmodule

// File: tb/tb_dht_onewire_reader.sv
// Directed bench for dht_onewire_reader: three instances (defaults, 4 clk/us 16-bit, short start pulse)
// driven by a behavioural sensor on open-drain lines with pull-ups.
module tb_dht_onewire_reader;
    localparam logic [39:0] GOOD = 40'h35_00_18_00_4D;
    localparam logic [39:0] BAD  = 40'h35_00_18_00_4E;

    logic       clk1M = 1'b0;
    logic       rst_n;
    logic [2:0] sens_low;
    wire        line_a, line_b, line_c;
    int         n_vec = 0;
    int         n_mis = 0;
    int         dv [3];
    int         ce [3];
    int         te [3];

    always #5 clk1M = ~clk1M;

    pullup (line_a);
    pullup (line_b);
    pullup (line_c);
    assign line_a = sens_low[0] ? 1'b0 : 1'bz;
    assign line_b = sens_low[1] ? 1'b0 : 1'bz;
    assign line_c = sens_low[2] ? 1'b0 : 1'bz;

    dht_onewire_reader_if #(.N_BITS(40)) if_a ();
    dht_onewire_reader_if #(.N_BITS(16)) if_b ();
    dht_onewire_reader_if #(.N_BITS(40)) if_c ();

    dht_onewire_reader #(.CLK_PER_US(1), .START_LOW_US(18000), .RESP_TIMEOUT_US(200),
                         .BIT_THRESH_US(50), .N_BITS(40), .CHK_EN(1'b1))
        u_a (.clk1M(clk1M), .rst_n(rst_n), .dht_io(line_a), .bus(if_a));
    dht_onewire_reader #(.CLK_PER_US(4), .START_LOW_US(1000), .RESP_TIMEOUT_US(200),
                         .BIT_THRESH_US(50), .N_BITS(16), .CHK_EN(1'b1))
        u_b (.clk1M(clk1M), .rst_n(rst_n), .dht_io(line_b), .bus(if_b));
    dht_onewire_reader #(.CLK_PER_US(1), .START_LOW_US(1000), .RESP_TIMEOUT_US(200),
                         .BIT_THRESH_US(50), .N_BITS(40), .CHK_EN(1'b1))
        u_c (.clk1M(clk1M), .rst_n(rst_n), .dht_io(line_c), .bus(if_c));

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk1M) begin
        if (if_a.data_valid)  dv[0]++;
        if (if_b.data_valid)  dv[1]++;
        if (if_c.data_valid)  dv[2]++;
        if (if_a.chk_err)     ce[0]++;
        if (if_b.chk_err)     ce[1]++;
        if (if_c.chk_err)     ce[2]++;
        if (if_a.timeout_err) te[0]++;
        if (if_b.timeout_err) te[1]++;
        if (if_c.timeout_err) te[2]++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int cpu(input int idx);
        return (idx == 1) ? 4 : 1;
    endfunction

    function automatic logic line_of(input int idx);
        case (idx)
            0:       return line_a;
            1:       return line_b;
            default: return line_c;
        endcase
    endfunction

    function automatic logic [39:0] dout(input int idx);
        case (idx)
            0:       return if_a.data_out;
            1:       return {24'h0, if_b.data_out};
            default: return if_c.data_out;
        endcase
    endfunction

    function automatic int bcnt(input int idx);
        case (idx)
            0:       return int'(if_a.bit_cnt);
            1:       return int'(if_b.bit_cnt);
            default: return int'(if_c.bit_cnt);
        endcase
    endfunction

    function automatic logic busy_of(input int idx);
        case (idx)
            0:       return if_a.busy;
            1:       return if_b.busy;
            default: return if_c.busy;
        endcase
    endfunction

    task automatic set_trig(input int idx, input logic v);
        case (idx)
            0:       if_a.trigger = v;
            1:       if_b.trigger = v;
            default: if_c.trigger = v;
        endcase
    endtask

    task automatic hold(input int idx, input logic low, input int us);
        sens_low[idx] = low;
        repeat (us * cpu(idx)) @(negedge clk1M);
    endtask

    // Raise trigger, measure latency to line low and the low duration; returns with line released.
    task automatic start_read(input int idx, output int lat, output int low_len);
        set_trig(idx, 1'b1);
        lat = 0;
        while (line_of(idx) !== 1'b0 && lat < 50) begin
            @(negedge clk1M);
            lat++;
        end
        low_len = 0;
        while (line_of(idx) === 1'b0 && low_len < 100000) begin
            low_len++;
            @(negedge clk1M);
        end
        set_trig(idx, 1'b0);
    endtask

    // Sensor answer: 80/80 us response, then nbits MSB first, 50 us low per bit.
    task automatic send(input int idx, input logic [39:0] frame, input int nbits,
                        input int hi0, input int hi1);
        hold(idx, 1'b0, 30);
        hold(idx, 1'b1, 80);
        hold(idx, 1'b0, 80);
        for (int i = nbits - 1; i >= 0; i--) begin
            hold(idx, 1'b1, 50);
            hold(idx, 1'b0, frame[i] ? hi1 : hi0);
        end
        hold(idx, 1'b1, 50);
        sens_low[idx] = 1'b0;
        repeat (10) @(negedge clk1M);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int lat, low_len, m;
        rst_n    = 1'b0;
        sens_low = '0;
        set_trig(0, 1'b0);
        set_trig(1, 1'b0);
        set_trig(2, 1'b0);
        repeat (3) @(negedge clk1M);
        check("rst_data_a", dout(0), 40'h0);
        check("rst_busy_a", busy_of(0), 1'b0);
        check("rst_line_a", line_of(0), 1'b1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk1M);

        // Instance A: default timing, good frame
        start_read(0, lat, low_len);
        check("a_latency", lat, 3);
        check("a_start_low", low_len, 18000);
        check("a_busy", busy_of(0), 1'b1);
        send(0, GOOD, 40, 26, 70);
        check("a_data", dout(0), GOOD);
        check("a_valid_cnt", dv[0], 1);
        check("a_chk_cnt", ce[0], 0);
        check("a_to_cnt", te[0], 0);
        check("a_busy_end", busy_of(0), 1'b0);

        // Instance B: 4 clk/us, 50 us high -> 0, 51 us high -> 1
        start_read(1, lat, low_len);
        check("b_latency", lat, 3);
        check("b_start_low", low_len, 4000);
        send(1, 40'h5A5A, 16, 50, 51);
        check("b_thresh_data", dout(1), 40'h5A5A);
        check("b_valid_cnt", dv[1], 1);

        // Instance C: good, then bad checksum
        start_read(2, lat, low_len);
        check("c_start_low", low_len, 1000);
        send(2, GOOD, 40, 26, 70);
        check("c_good_data", dout(2), GOOD);
        check("c_good_valid", dv[2], 1);
        start_read(2, lat, low_len);
        send(2, BAD, 40, 26, 70);
        check("c_bad_chk", ce[2], 1);
        check("c_bad_valid", dv[2], 1);
        check("c_bad_data", dout(2), GOOD);

        // No sensor: timeout 201 ticks after release
        start_read(2, lat, low_len);
        m = 0;
        while (!if_c.timeout_err && m < 1000) begin
            @(negedge clk1M);
            m++;
        end
        check("c_to_ticks", m, 201);
        @(negedge clk1M);
        check("c_to_cnt", te[2], 1);
        check("c_to_busy", busy_of(2), 1'b0);
        check("c_to_valid", dv[2], 1);

        // Sensor stops after 12 bits
        start_read(2, lat, low_len);
        send(2, GOOD, 12, 26, 70);
        repeat (300) @(negedge clk1M);
        check("c_stop_to_cnt", te[2], 2);
        check("c_stop_bits", bcnt(2), 12);
        check("c_stop_data", dout(2), GOOD);
        check("c_stop_busy", busy_of(2), 1'b0);

        // Retrigger during response, then reset mid-data
        start_read(2, lat, low_len);
        hold(2, 1'b0, 30);
        hold(2, 1'b1, 80);
        set_trig(2, 1'b1);
        hold(2, 1'b0, 80);
        set_trig(2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            hold(2, 1'b1, 50);
            hold(2, 1'b0, 70);
        end
        hold(2, 1'b1, 10);
        sens_low[2] = 1'b0;
        check("c_retrig_bits", bcnt(2), 5);
        check("c_retrig_busy", busy_of(2), 1'b1);
        rst_n = 1'b0;
        #1;
        check("c_rst_data", dout(2), 40'h0);
        check("c_rst_bits", bcnt(2), 0);
        check("c_rst_busy", busy_of(2), 1'b0);
        @(negedge clk1M);
        rst_n = 1'b1;
        repeat (5) @(negedge clk1M);

        // Reset during the start pulse releases the line at once
        set_trig(2, 1'b1);
        repeat (20) @(negedge clk1M);
        check("c_start_drive", line_of(2), 1'b0);
        rst_n = 1'b0;
        #1;
        check("c_rst_release", line_of(2), 1'b1);
        @(negedge clk1M);
        set_trig(2, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk1M);

        // Fresh read after reset
        start_read(2, lat, low_len);
        check("c_post_low", low_len, 1000);
        send(2, GOOD, 40, 26, 70);
        check("c_post_data", dout(2), GOOD);
        check("c_post_valid", dv[2], 2);
        check("c_post_chk", ce[2], 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/dht_onewire_reader.md
Name: dht_onewire_reader

Overview:
Parametrised single-wire reader for DHT11/DHT22-class humidity/temperature sensors. A rising edge on a trigger input starts a read, typically from the 5 s strobe. The block drives the start pulse open-drain, times the sensor response and N_BITS data pulses, and validates the checksum. Results and error status go to the display/control logic. Unlike the previous reader, it adds reset, configurable timing, per-phase timeouts, checksum checking and explicit status outputs.

Parameters:
CLK_PER_US, 1, clk1M cycles per microsecond; all timing constants are multiplied by it.
START_LOW_US, 18000, host start-pulse low time (use 1000 for DHT22).
RESP_TIMEOUT_US, 200, maximum wait for any expected edge before aborting.
BIT_THRESH_US, 50, a data-high time strictly greater than this decodes as 1, otherwise 0.
N_BITS, 40, data bits per frame; must be a multiple of 8 and at least 16.
CHK_EN, 1, when 1 the last byte must equal the mod-256 sum of the preceding bytes.

Ports:
clk1M  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
trigger  in  1  read request; the rising edge is used.
dht_io  inout  1  sensor data line; the block drives only 0, otherwise high-Z (external pull-up).
data_out  out  N_BITS  last good frame, MSB first as received.
data_valid  out  1  one-cycle pulse when data_out is updated.
chk_err  out  1  one-cycle pulse when a full frame fails the checksum.
timeout_err  out  1  one-cycle pulse when a read aborts on timeout.
busy  out  1  high from trigger acceptance until return to IDLE.
bit_cnt  out  log2(N_BITS)+1  bits received in the current frame (debug).

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, line released, all counters 0.
  - All outputs are 0, including data_out.
  - Deasserting reset mid-read leaves the line released and discards the partial frame.
- Input synchronisation: trigger and dht_io each pass through 2 flops before edge detection. Edges are registered, so the trigger-to-drive-low latency is 3 cycles.
- Tick counter: 1 tick = 1 µs, from a prescaler of CLK_PER_US. The phase counter is 20 bits wide and saturates; it never wraps.
- States:
  - IDLE: on a trigger edge go to START_LOW, drive 0, clear counter and shift register, set busy.
  - START_LOW: after START_LOW_US ticks, release the line and go to WAIT_RESP.
  - WAIT_RESP: synced line falls -> RESP_LOW.
  - RESP_LOW: line rises -> RESP_HIGH.
  - RESP_HIGH: line falls -> BIT_LOW.
  - BIT_LOW: line rises -> BIT_HIGH, counter cleared.
  - BIT_HIGH: on the line falling, shift in (count > BIT_THRESH_US) and increment bit_cnt. If bit_cnt reaches N_BITS go to CHECK, else go to BIT_LOW.
  - CHECK (1 cycle):
    - If CHK_EN=0, or the sum passes: load data_out and pulse data_valid.
    - Otherwise pulse chk_err and leave data_out unchanged.
    - Then go to IDLE.
  - Timeout: in any state from WAIT_RESP through BIT_HIGH, the counter exceeding RESP_TIMEOUT_US pulses timeout_err, releases the line and returns to IDLE. data_out is unchanged.
- Edge counting: the counter clears on every state transition. The counter measures time in the current state only.
- busy: drops in the same cycle the state returns to IDLE.
- Triggers while busy are ignored, not queued. A trigger edge in the cycle busy drops is also ignored.
- Checksum: 8-bit wraparound sum of bytes N_BITS/8-1 down to 1 (MSB-first byte order), compared with byte 0.
- The line is never driven 1. dht_io = 0 only in START_LOW.
- data_valid, chk_err and timeout_err are mutually exclusive and at most one pulse per read.

Test Plan:
- Good frame, defaults: a sensor model answers 80/80 µs and sends 0x35_00_18_00_4D (0x35+0x18=0x4D). Required: line low for 18000 cycles, data_out=0x350018004D, one data_valid pulse, busy low afterward.
- Bad checksum: the same frame with last byte 0x4E. Required: chk_err pulse, data_out keeps its previous value, no data_valid.
- No sensor (line stays pulled up): required timeout_err 201 ticks after release, no data_valid, busy low.
- Sensor stops after 12 bits (line held high): required timeout_err, bit_cnt had reached 12, data_out unchanged.
- Trigger pulses during a read, and rst_n asserted mid-data: the retrigger is ignored. Reset releases the line immediately and zeroes all outputs. A new trigger after reset completes normally.
- Threshold and scaling: CLK_PER_US=4, START_LOW_US=1000, bit highs of 50 µs and 51 µs. Required: start low for 4000 cycles; the 50 µs high decodes as 0 and the 51 µs high as 1.
